// File: rtl/vga_pkg.sv
// +------------------------------------------------------------------+
// | vga_pkg: 1024x768@60 raster constants and axis timing helpers     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

    localparam int unsigned TOTAL_HOR_PIXELS = 1344;
    localparam int unsigned TOTAL_VER_PIXELS = 806;
    localparam int unsigned HOR_BLANK_START  = 1024;
    localparam int unsigned HOR_BLANK_END    = 1344;
    localparam int unsigned HOR_SYNC_START   = 1048;
    localparam int unsigned HOR_SYNC_END     = 1184;
    localparam int unsigned VER_BLANK_START  = 768;
    localparam int unsigned VER_BLANK_END    = 806;
    localparam int unsigned VER_SYNC_START   = 771;
    localparam int unsigned VER_SYNC_END     = 777;

    localparam logic        SYNC_POL_POS     = 1'b1;
    localparam int unsigned COUNT_W          = 11;

    typedef struct packed {
        int unsigned total;
        int unsigned blnk_s;
        int unsigned blnk_e;
        int unsigned sync_s;
        int unsigned sync_e;
    } axis_timing_t;

    // Half-open window test [lo, hi)
    function automatic logic in_window(input logic [COUNT_W-1:0] pos,
                                       input logic [COUNT_W-1:0] lo,
                                       input logic [COUNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// +------------------------------------------------------------------+
// | vga_axis_counter: wrap counter with registered blank/sync decode  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL    = TOTAL_HOR_PIXELS,
    parameter int unsigned BLNK_S   = HOR_BLANK_START,
    parameter int unsigned BLNK_E   = HOR_BLANK_END,
    parameter int unsigned SYNC_S   = HOR_SYNC_START,
    parameter int unsigned SYNC_E   = HOR_SYNC_END,
    parameter logic        SYNC_POL = SYNC_POL_POS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               blnk,
    output logic               sync
);

    localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] BLNK_LO = COUNT_W'(BLNK_S);
    localparam logic [COUNT_W-1:0] BLNK_HI = COUNT_W'(BLNK_E);
    localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_S);
    localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_E);

    logic [COUNT_W-1:0] count_d, count_q;
    logic               blnk_d, blnk_q;
    logic               sync_d, sync_q;

    // Flags decode the next count so they line up with the registered count.
    always_comb begin
        wrap    = inc && (count_q == LAST);
        count_d = count_q;
        if (clear || wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
        blnk_d = in_window(count_d, BLNK_LO, BLNK_HI);
        sync_d = in_window(count_d, SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            blnk_q  <= 1'b0;
            sync_q  <= ~SYNC_POL;
        end else begin
            count_q <= count_d;
            blnk_q  <= blnk_d;
            sync_q  <= sync_d;
        end
    end

    assign count = count_q;
    assign blnk  = blnk_q;
    assign sync  = sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// +------------------------------------------------------------------+
// | vga_timing_gen: free-running VGA raster timing, frame markers     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL  = TOTAL_HOR_PIXELS,
    parameter int unsigned V_TOTAL  = TOTAL_VER_PIXELS,
    parameter int unsigned H_BLNK_S = HOR_BLANK_START,
    parameter int unsigned H_BLNK_E = HOR_BLANK_END,
    parameter int unsigned V_BLNK_S = VER_BLANK_START,
    parameter int unsigned V_BLNK_E = VER_BLANK_END,
    parameter int unsigned H_SYNC_S = HOR_SYNC_START,
    parameter int unsigned H_SYNC_E = HOR_SYNC_END,
    parameter int unsigned V_SYNC_S = VER_SYNC_START,
    parameter int unsigned V_SYNC_E = VER_SYNC_END,
    parameter logic        SYNC_POL = SYNC_POL_POS,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               restart,
    output logic [COUNT_W-1:0] hcount,
    output logic [COUNT_W-1:0] vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               sof,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam axis_timing_t H_TIMING = '{H_TOTAL, H_BLNK_S, H_BLNK_E, H_SYNC_S, H_SYNC_E};
    localparam axis_timing_t V_TIMING = '{V_TOTAL, V_BLNK_S, V_BLNK_E, V_SYNC_S, V_SYNC_E};

    logic h_wrap;
    logic v_wrap;
    logic v_inc;

    logic              line_start_d, line_start_q;
    logic              sof_d, sof_q;
    logic [FCNT_W-1:0] frame_cnt_d, frame_cnt_q;

    assign v_inc = en & h_wrap;

    vga_axis_counter #(
        .TOTAL    (H_TIMING.total),
        .BLNK_S   (H_TIMING.blnk_s),
        .BLNK_E   (H_TIMING.blnk_e),
        .SYNC_S   (H_TIMING.sync_s),
        .SYNC_E   (H_TIMING.sync_e),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .clear (restart),
        .count (hcount),
        .wrap  (h_wrap),
        .blnk  (hblnk),
        .sync  (hsync)
    );

    vga_axis_counter #(
        .TOTAL    (V_TIMING.total),
        .BLNK_S   (V_TIMING.blnk_s),
        .BLNK_E   (V_TIMING.blnk_e),
        .SYNC_S   (V_TIMING.sync_s),
        .SYNC_E   (V_TIMING.sync_e),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (v_inc),
        .clear (restart),
        .count (vcount),
        .wrap  (v_wrap),
        .blnk  (vblnk),
        .sync  (vsync)
    );

    // A restart re-aligns to the origin and is reported as a new frame,
    // but only a natural frame wrap counts as a completed frame.
    always_comb begin
        line_start_d = restart | h_wrap;
        sof_d        = restart | v_wrap;
        frame_cnt_d  = frame_cnt_q;
        if (!restart && v_wrap) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_q <= 1'b0;
            sof_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            line_start_q <= line_start_d;
            sof_q        <= sof_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign line_start = line_start_q;
    assign sof        = sof_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// +------------------------------------------------------------------+
// | tb_vga_timing_gen: bench for full-size and reduced raster configs |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en0, rs0, en1, rs1;

    logic [10:0] hc0, vc0, hc1, vc1;
    logic        hb0, vb0, hs0, vs0, ls0, sf0;
    logic        hb1, vb1, hs1, vs1, ls1, sf1;
    logic [15:0] fc0;
    logic [2:0]  fc1;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en0), .restart(rs0),
        .hcount(hc0), .vcount(vc0), .hblnk(hb0), .vblnk(vb0),
        .hsync(hs0), .vsync(vs0), .line_start(ls0), .sof(sf0), .frame_cnt(fc0)
    );

    // Reduced raster with active-low sync so frame wraps fit in a short run
    vga_timing_gen #(
        .H_TOTAL(10), .V_TOTAL(8),
        .H_BLNK_S(6), .H_BLNK_E(10), .V_BLNK_S(5), .V_BLNK_E(8),
        .H_SYNC_S(7), .H_SYNC_E(9), .V_SYNC_S(6), .V_SYNC_E(7),
        .SYNC_POL(1'b0), .FCNT_W(3)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en1), .restart(rs1),
        .hcount(hc1), .vcount(vc1), .hblnk(hb1), .vblnk(vb1),
        .hsync(hs1), .vsync(vs1), .line_start(ls1), .sof(sf1), .frame_cnt(fc1)
    );

    // Reference raster description, index 0 = full size, 1 = reduced
    int unsigned HT [2] = '{1344, 10};
    int unsigned VT [2] = '{806, 8};
    int unsigned HBS[2] = '{1024, 6};
    int unsigned HBE[2] = '{1344, 10};
    int unsigned HSS[2] = '{1048, 7};
    int unsigned HSE[2] = '{1184, 9};
    int unsigned VBS[2] = '{768, 5};
    int unsigned VBE[2] = '{806, 8};
    int unsigned VSS[2] = '{771, 6};
    int unsigned VSE[2] = '{777, 7};
    logic        POL[2] = '{1'b1, 1'b0};
    int unsigned FMOD[2] = '{65536, 8};

    // Model state: linear pixel index within the frame plus frame count
    int unsigned p[2];
    int unsigned fcm[2];
    logic        lsm[2];
    logic        sfm[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            p[i] = 0; fcm[i] = 0; lsm[i] = 1'b0; sfm[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic e, input logic r);
        if (r) begin
            p[i] = 0; lsm[i] = 1'b1; sfm[i] = 1'b1;
        end else if (e) begin
            p[i]   = p[i] + 1;
            sfm[i] = 1'b0;
            if (p[i] == HT[i] * VT[i]) begin
                p[i]   = 0;
                sfm[i] = 1'b1;
                fcm[i] = (fcm[i] + 1) % FMOD[i];
            end
            lsm[i] = (p[i] % HT[i]) == 0;
        end else begin
            lsm[i] = 1'b0; sfm[i] = 1'b0;
        end
    endtask

    function automatic logic [43:0] model_vec(input int i);
        int unsigned h, v;
        logic hb, vb, hs, vs;
        h  = p[i] % HT[i];
        v  = p[i] / HT[i];
        hb = (h >= HBS[i]) && (h < HBE[i]);
        vb = (v >= VBS[i]) && (v < VBE[i]);
        hs = ((h >= HSS[i]) && (h < HSE[i])) ? POL[i] : ~POL[i];
        vs = ((v >= VSS[i]) && (v < VSE[i])) ? POL[i] : ~POL[i];
        return {11'(h), 11'(v), hb, vb, hs, vs, lsm[i], sfm[i], 16'(fcm[i])};
    endfunction

    function automatic logic [43:0] act0();
        return {hc0, vc0, hb0, vb0, hs0, vs0, ls0, sf0, fc0};
    endfunction

    function automatic logic [43:0] act1();
        return {hc1, vc1, hb1, vb1, hs1, vs1, ls1, sf1, 13'd0, fc1};
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got h=%0d v=%0d flags(hb,vb,hs,vs,ls,sof)=%b fc=%0d, want h=%0d v=%0d flags=%b fc=%0d",
                     name, $time, act[43:33], act[32:22], act[21:16], act[15:0],
                     exp[43:33], exp[32:22], exp[21:16], exp[15:0]);
        end
    endtask

    task automatic tick(input logic e0, input logic r0, input logic e1, input logic r1);
        en0 = e0; rs0 = r0; en1 = e1; rs1 = r1;
        @(posedge clk);
        #1;
        model_step(0, e0, r0);
        model_step(1, e1, r1);
        check("model_full", act0(), model_vec(0));
        check("model_small", act1(), model_vec(1));
    endtask

    typedef struct {
        int   n;
        logic en;
        logic rs;
        int   h;
        int   v;
        logic hb;
        logic hs;
        logic ls;
        logic sof;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1023, 1'b1, 1'b0, 1023, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,    1'b1, 1'b0, 1024, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{23,   1'b1, 1'b0, 1047, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1,    1'b1, 1'b0, 1048, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{135,  1'b1, 1'b0, 1183, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1,    1'b1, 1'b0, 1184, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{159,  1'b1, 1'b0, 1343, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1,    1'b1, 1'b0, 0,    1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1,    1'b1, 1'b0, 1,    1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{499,  1'b1, 1'b0, 500,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{5,    1'b0, 1'b0, 500,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1,    1'b1, 1'b0, 501,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{199,  1'b1, 1'b0, 700,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1,    1'b1, 1'b1, 0,    0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1,    1'b0, 1'b1, 0,    0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1,    1'b0, 1'b0, 0,    0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        en0 = 1'b0; rs0 = 1'b0; en1 = 1'b0; rs1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_full",  act0(), {11'd0, 11'd0, 6'b000000, 16'd0});
        check("reset_small", act1(), {11'd0, 11'd0, 6'b001100, 16'd0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Directed table on the full-size raster; reduced raster free-runs
        for (int k = 0; k < 16; k++) begin
            repeat (tbl[k].n) tick(tbl[k].en, tbl[k].rs, 1'b1, 1'b0);
            check($sformatf("table_%0d", k), act0(),
                  {11'(tbl[k].h), 11'(tbl[k].v), tbl[k].hb, 1'b0, tbl[k].hs, 1'b0,
                   tbl[k].ls, tbl[k].sof, 16'd0});
        end

        // Randomized enable / restart against the reference model
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        // Async reset between edges while the reduced raster sits in vsync
        begin
            int seek = 0;
            while (!((p[1] % HT[1]) == 8 && (p[1] / HT[1]) == 6) && seek < 200) begin
                tick(1'b1, 1'b0, 1'b1, 1'b0);
                seek++;
            end
            n_checks++;
            if (seek >= 200) begin
                n_fail++;
                $display("FAIL seek_vsync: got %0d cycles, want fewer than 200", seek);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_full",  act0(), {11'd0, 11'd0, 6'b000000, 16'd0});
        check("async_reset_small", act1(), {11'd0, 11'd0, 6'b001100, 16'd0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        check("resume_full", act0(), {11'd1, 11'd0, 6'b000000, 16'd0});
        repeat (200) tick(1'b1, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Free-running VGA raster timing generator for 1024x768 @ 60 Hz on the 65 MHz pixel clock, built from vga_pkg constants. Produces registered hcount/vcount, blanking and sync strobes, plus frame/line markers. It feeds every downstream draw stage (background, sprite and rect renderers) and the output register that drives the VGA pins.

Parameters:
H_TOTAL, vga_pkg::TOTAL_HOR_PIXELS (1344), pixel clocks per line
V_TOTAL, vga_pkg::TOTAL_VER_PIXELS (806), lines per frame
H_BLNK_S / H_BLNK_E, 1024 / 1344, hblnk active for H_BLNK_S <= hcount < H_BLNK_E
V_BLNK_S / V_BLNK_E, 768 / 806, vblnk active for V_BLNK_S <= vcount < V_BLNK_E
H_SYNC_S / H_SYNC_E, 1048 / 1184, hsync window [S,E)
V_SYNC_S / V_SYNC_E, 771 / 777, vsync window [S,E)
SYNC_POL, 1'b1, asserted sync level; deasserted level is ~SYNC_POL
FCNT_W, 16, frame counter width

Ports:
clk  in  1  65 MHz pixel clock
rst_n  in  1  asynchronous reset, active-low
en  in  1  pixel advance enable; counters hold when low
restart  in  1  synchronous re-align to raster origin (0,0)
hcount  out  11  horizontal position 0..H_TOTAL-1
vcount  out  11  vertical position 0..V_TOTAL-1
hblnk  out  1  horizontal blanking
vblnk  out  1  vertical blanking
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
line_start  out  1  1-clk pulse on entering hcount==0
sof  out  1  1-clk pulse on entering (0,0)
frame_cnt  out  FCNT_W  completed-frame count, wraps modulo 2^FCNT_W

Behaviour:
- All outputs registered. Flags are decoded from the next-state counts, so hblnk/vblnk/hsync/vsync always describe the hcount/vcount shown in the same cycle (zero relative skew).
- Reset (async assert, sync release): hcount=vcount=0, hblnk=vblnk=0, hsync=vsync=~SYNC_POL, line_start=sof=0, frame_cnt=0. Assertion mid-frame takes effect without a clock edge.
- Advance (en=1, restart=0):
  - hcount+1; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps to 0 after V_TOTAL-1 at the line wrap.
  - A frame wrap (1343,805)->(0,0) sets sof=1 and line_start=1, and increments frame_cnt, which wraps from all-ones to 0.
- Line wrap without frame wrap: line_start=1, sof=0.
- Hold (en=0, restart=0): counts and flags hold; line_start=sof=0.
- Restart (priority over en): next cycle hcount=vcount=0, flags decoded for (0,0), sof=line_start=1, frame_cnt unchanged. A restart while already at (0,0) still pulses sof.
- Sync windows lie inside their blanking windows; frame length = 1344*806 = 1,083,264 enabled cycles.
- No other states; the counters are the only state plus frame_cnt.

Decomposition:
- vga_pkg additions: SYNC_POL_POS constant, COUNT_W=11 localparam, and an axis-timing struct typedef {total, blnk_s, blnk_e, sync_s, sync_e}.
- One sub-module, vga_axis_counter. It is a wrap counter with inc/clear inputs, a wrap output and registered blank/sync decode. It is instantiated for the horizontal axis (inc=en) and the vertical axis (inc=en & h_wrap), with restart as clear on both.
- Top level adds frame_cnt, the sof/line_start pulses and the restart priority.

Test Plan:
- Release rst_n, hold en=1 -> hcount counts 0..1343; hblnk rises at hcount=1024; hsync asserts at 1048 and deasserts at 1184; hblnk falls when hcount wraps to 0.
- Line wrap at (1343,0) -> next cycle (0,1), line_start=1 for one clk, sof=0.
- Run 1,083,264 enabled cycles -> vcount wraps 805->0, sof=1 once, frame_cnt 0->1; vsync asserted exactly for vcount 771..776; vblnk for 768..805.
- At hcount=500, drop en for 5 clks -> hcount and all flags hold at 500 with no pulses; resume -> 501.
- At (700,300), pulse restart with en=1 -> next cycle (0,0), sof=1, line_start=1, frame_cnt unchanged, hsync/vsync deasserted.
- Assert rst_n low between edges at (1100,780) -> all outputs immediately return to reset values (sync deasserted), frame_cnt=0; counting resumes from (0,0) after release.
